// File: rtl/branch_predictor_if.sv
// Branch predictor bus: fetch-side lookup, execute-side update and the
// misprediction counter, bundled so the predictor and its driver share one view.
//
// Handshake: there is no ready. The lookup is combinational from PCF and is
// valid in the same cycle. An update is a single-cycle strobe: when upd_valid
// is high at a rising clk edge, all upd_* fields are sampled on that edge and
// are otherwise ignored.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
);
    logic [XLEN-1:0]  PCF;
    logic             predict_hit;
    logic             predict_taken;
    logic [XLEN-1:0]  predict_target;
    logic [IDX_W-1:0] predict_index;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_branch;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_mispredict;
    logic [15:0]      mispred_cnt;

    modport master (
        output PCF, upd_valid, upd_index, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_mispredict,
        input  predict_hit, predict_taken, predict_target, predict_index,
               mispred_cnt
    );

    modport slave (
        input  PCF, upd_valid, upd_index, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_mispredict,
        output predict_hit, predict_taken, predict_target, predict_index,
               mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// MODE 0 indexes by PC alone (bimodal); MODE 1 XORs a non-speculative global
// history into the index (gshare). Lookups see pre-update table contents.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int MODE    = 0,
    parameter int HIST_W  = 4
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [HIST_W-1:0]  ghr_q;
    logic [15:0]        mispred_q;

    logic [IDX_W-1:0]   hist_ext;
    logic [IDX_W-1:0]   lk_idx;
    logic               lk_hit;
    logic               lk_taken;

    logic               upd_jump;
    logic               upd_branch;
    logic               upd_hit;
    logic               alloc;
    logic               wr_target;
    logic [IDX_W-1:0]   ui;

    // Word-offset bits of both PCs never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PCF[1:0], bus.upd_pc[IDX_W+1:0]};

    // Lookup index: PC word index, optionally XORed with zero-extended history.
    always_comb begin
        hist_ext = '0;
        hist_ext[HIST_W-1:0] = ghr_q;
        lk_idx = bus.PCF[IDX_W+1:2];
        if (MODE == 1) begin
            lk_idx = lk_idx ^ hist_ext;
        end
    end

    // Lookup: hit on valid and tag match; jumps are always taken.
    always_comb begin
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == bus.PCF[XLEN-1:IDX_W+2]);
        lk_taken = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][1]);
    end

    assign bus.predict_hit    = lk_hit;
    assign bus.predict_taken  = lk_taken;
    assign bus.predict_target = lk_taken ? target_q[lk_idx] : bus.PCF + XLEN'(4);
    assign bus.predict_index  = lk_idx;
    assign bus.mispred_cnt    = mispred_q;

    // Update decode; an instruction flagged as both branch and jump is a jump.
    always_comb begin
        ui         = bus.upd_index;
        upd_jump   = bus.upd_valid && bus.upd_is_jump;
        upd_branch = bus.upd_valid && bus.upd_is_branch && !bus.upd_is_jump;
        upd_hit    = valid_q[ui] && (tag_q[ui] == bus.upd_pc[XLEN-1:IDX_W+2]);
        alloc      = !upd_hit && (upd_jump || (upd_branch && bus.upd_taken));
        wr_target  = alloc || (upd_hit && (upd_jump || (upd_branch && bus.upd_taken)));
    end

    // Control state: valid bits, direction counters, history, mispredict count.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            ghr_q     <= '0;
            mispred_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else begin
            if (alloc) begin
                valid_q[ui] <= 1'b1;
                cnt_q[ui]   <= 2'b10;
            end else if (upd_hit && upd_branch) begin
                if (bus.upd_taken && cnt_q[ui] != 2'b11) begin
                    cnt_q[ui] <= cnt_q[ui] + 2'd1;
                end else if (!bus.upd_taken && cnt_q[ui] != 2'b00) begin
                    cnt_q[ui] <= cnt_q[ui] - 2'd1;
                end
            end
            if (upd_branch) begin
                ghr_q <= HIST_W'({ghr_q, bus.upd_taken});
            end
            if (bus.upd_valid && bus.upd_mispredict && mispred_q != 16'hFFFF) begin
                mispred_q <= mispred_q + 16'd1;
            end
        end
    end

    // Payload state: tags, targets and jump flags; reset only discards the update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_target) begin
                target_q[ui] <= bus.upd_target;
            end
            if (alloc) begin
                tag_q[ui]  <= bus.upd_pc[XLEN-1:IDX_W+2];
                jump_q[ui] <= upd_jump;
            end else if (upd_hit && upd_jump) begin
                jump_q[ui] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance driven in
// lockstep and compared against a table-level reference model.
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int HIST_W  = 4;
    localparam int TAG_SH  = IDX_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus0 ();
    branch_predictor_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus1 ();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .MODE(0), .HIST_W(HIST_W))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .MODE(1), .HIST_W(HIST_W))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit          m_valid [2][ENTRIES];
    logic [31:0] m_tag   [2][ENTRIES];
    logic [31:0] m_tgt   [2][ENTRIES];
    int          m_cnt   [2][ENTRIES];
    bit          m_jmp   [2][ENTRIES];
    int          m_hist  [2];
    int          m_mis   [2];

    logic [31:0] s_pc, s_upc, s_utgt;
    bit          s_uv, s_ub, s_uj, s_ut, s_um;
    int          s_uidx [2];

    function automatic int model_index(int m, logic [31:0] pc);
        int idx;
        idx = int'((pc / 4) % ENTRIES);
        if (m == 1) idx = idx ^ (m_hist[1] % (1 << HIST_W));
        return idx;
    endfunction

    function automatic bit exp_hit(int m, logic [31:0] pc);
        int i;
        i = model_index(m, pc);
        return m_valid[m][i] && (m_tag[m][i] == (pc >> TAG_SH));
    endfunction

    function automatic bit exp_taken(int m, logic [31:0] pc);
        int i;
        i = model_index(m, pc);
        return exp_hit(m, pc) && (m_jmp[m][i] || m_cnt[m][i] >= 2);
    endfunction

    function automatic logic [31:0] exp_target(int m, logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        return exp_taken(m, pc) ? m_tgt[m][model_index(m, pc)] : nxt;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[m][i] = 0;
                m_cnt[m][i]   = 1;
            end
            m_hist[m] = 0;
            m_mis[m]  = 0;
        end
    endtask

    task automatic model_update(int m);
        int i;
        bit jmp, br, hit;
        if (!s_uv) return;
        if (s_um && m_mis[m] < 65535) m_mis[m]++;
        jmp = s_uj;
        br  = s_ub && !s_uj;
        if (!jmp && !br) return;
        i   = s_uidx[m];
        hit = m_valid[m][i] && (m_tag[m][i] == (s_upc >> TAG_SH));
        if (hit) begin
            if (jmp) begin
                m_tgt[m][i] = s_utgt;
                m_jmp[m][i] = 1;
            end else if (s_ut) begin
                m_cnt[m][i] = (m_cnt[m][i] == 3) ? 3 : m_cnt[m][i] + 1;
                m_tgt[m][i] = s_utgt;
            end else begin
                m_cnt[m][i] = (m_cnt[m][i] == 0) ? 0 : m_cnt[m][i] - 1;
            end
        end else if (jmp || s_ut) begin
            m_valid[m][i] = 1;
            m_tag[m][i]   = s_upc >> TAG_SH;
            m_tgt[m][i]   = s_utgt;
            m_jmp[m][i]   = jmp;
            m_cnt[m][i]   = 2;
        end
        if (br) m_hist[m] = (m_hist[m] * 2 + int'(s_ut)) % (1 << HIST_W);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(logic [31:0] pc, bit uv, bit ub, bit uj, bit ut,
                          logic [31:0] upc, logic [31:0] utgt, bit um, bit rnd_idx);
        s_pc = pc; s_uv = uv; s_ub = ub; s_uj = uj; s_ut = ut;
        s_upc = upc; s_utgt = utgt; s_um = um;
        for (int m = 0; m < 2; m++)
            s_uidx[m] = rnd_idx ? int'($urandom_range(0, ENTRIES - 1)) : model_index(m, upc);
        bus0.PCF = pc;            bus1.PCF = pc;
        bus0.upd_valid = uv;      bus1.upd_valid = uv;
        bus0.upd_is_branch = ub;  bus1.upd_is_branch = ub;
        bus0.upd_is_jump = uj;    bus1.upd_is_jump = uj;
        bus0.upd_taken = ut;      bus1.upd_taken = ut;
        bus0.upd_pc = upc;        bus1.upd_pc = upc;
        bus0.upd_target = utgt;   bus1.upd_target = utgt;
        bus0.upd_mispredict = um; bus1.upd_mispredict = um;
        bus0.upd_index = IDX_W'(s_uidx[0]);
        bus1.upd_index = IDX_W'(s_uidx[1]);
    endtask

    task automatic lookup(logic [31:0] pc);
        set_in(pc, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic upd(logic [31:0] upc, bit ub, bit uj, bit ut, logic [31:0] utgt);
        set_in(upc, 1, ub, uj, ut, upc, utgt, 0, 0);
    endtask

    // Apply the current inputs at the next rising edge, return at the falling edge.
    task automatic advance();
        if (rst) model_reset();
        else begin
            model_update(0);
            model_update(1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lookup(32'h0);
        advance();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        lookup(32'h100);
        advance();
        advance();
        rst = 1'b0;
        lookup(32'h100);
        #1;
        checks += 5;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", bus0.predict_hit); end
        if (bus0.predict_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", bus0.predict_taken); end
        if (bus0.predict_target !== 32'h104) begin errors++; $display("FAIL reset_target got=%h exp=00000104", bus0.predict_target); end
        if (bus0.mispred_cnt !== 16'h0) begin errors++; $display("FAIL reset_mispred got=%h exp=0000", bus0.mispred_cnt); end
        if (bus1.predict_hit !== 1'b0) begin errors++; $display("FAIL reset_hit_gshare got=%b exp=0", bus1.predict_hit); end
        lookup(32'hFFFF_FFFC);
        #1;
        checks++;
        if (bus0.predict_target !== 32'h0) begin errors++; $display("FAIL wrap_target got=%h exp=00000000", bus0.predict_target); end
        advance();
    endtask

    task automatic test_allocate();
        upd(32'h100, 1, 0, 1, 32'h80);
        #1;
        checks++;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL no_bypass_hit got=%b exp=0", bus0.predict_hit); end
        advance();
        lookup(32'h100);
        #1;
        checks += 4;
        if (bus0.predict_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%b exp=1", bus0.predict_hit); end
        if (bus0.predict_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got=%b exp=1", bus0.predict_taken); end
        if (bus0.predict_target !== 32'h80) begin errors++; $display("FAIL alloc_target got=%h exp=00000080", bus0.predict_target); end
        if (bus0.predict_index !== 4'h0) begin errors++; $display("FAIL alloc_index got=%h exp=0", bus0.predict_index); end
        advance();
    endtask

    // Counter walk from the freshly allocated state (weakly taken).
    task automatic test_counter();
        bit seq_t    [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit seq_pred [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [31:0] exp_tgt;
        for (int k = 0; k < 10; k++) begin
            upd(32'h100, 1, 0, seq_t[k], 32'h80);
            advance();
            lookup(32'h100);
            #1;
            exp_tgt = seq_pred[k] ? 32'h80 : 32'h104;
            checks += 3;
            if (bus0.predict_hit !== 1'b1) begin errors++; $display("FAIL cnt_hit step=%0d got=%b exp=1", k, bus0.predict_hit); end
            if (bus0.predict_taken !== seq_pred[k]) begin errors++; $display("FAIL cnt_taken step=%0d got=%b exp=%b", k, bus0.predict_taken, seq_pred[k]); end
            if (bus0.predict_target !== exp_tgt) begin errors++; $display("FAIL cnt_target step=%0d got=%h exp=%h", k, bus0.predict_target, exp_tgt); end
            advance();
        end
    endtask

    task automatic test_jump();
        // jump allocation stays taken even when the counter falls to 0
        upd(32'h104, 0, 1, 1, 32'h400);
        advance();
        for (int k = 0; k < 3; k++) begin
            upd(32'h104, 1, 0, 0, 32'h0);
            advance();
        end
        lookup(32'h104);
        #1;
        checks += 2;
        if (bus0.predict_taken !== 1'b1) begin errors++; $display("FAIL jump_taken got=%b exp=1", bus0.predict_taken); end
        if (bus0.predict_target !== 32'h400) begin errors++; $display("FAIL jump_target got=%h exp=00000400", bus0.predict_target); end
        advance();
        // branch+jump together act as a jump hitting the not-taken branch entry
        upd(32'h100, 1, 1, 1, 32'h500);
        advance();
        lookup(32'h100);
        #1;
        checks += 2;
        if (bus0.predict_taken !== 1'b1) begin errors++; $display("FAIL both_taken got=%b exp=1", bus0.predict_taken); end
        if (bus0.predict_target !== 32'h500) begin errors++; $display("FAIL both_target got=%h exp=00000500", bus0.predict_target); end
        advance();
        // no allocation: not-taken branch, non-control update, invalid strobe
        upd(32'h108, 1, 0, 0, 32'h600);
        advance();
        upd(32'h10C, 0, 0, 1, 32'h600);
        advance();
        set_in(32'h0, 0, 1, 0, 1, 32'h110, 32'h600, 0, 0);
        advance();
        lookup(32'h108); #1;
        checks++;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_alloc got=%b exp=0", bus0.predict_hit); end
        lookup(32'h10C); #1;
        checks++;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL nonctl_alloc got=%b exp=0", bus0.predict_hit); end
        lookup(32'h110); #1;
        checks++;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL novalid_alloc got=%b exp=0", bus0.predict_hit); end
        advance();
    endtask

    task automatic test_alias();
        logic [31:0] alias_pc;
        alias_pc = 32'h100 + 32'(4 * ENTRIES);
        upd(alias_pc, 1, 0, 1, 32'h200);
        advance();
        lookup(32'h100); #1;
        checks += 2;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got=%b exp=0", bus0.predict_hit); end
        if (bus0.predict_target !== 32'h104) begin errors++; $display("FAIL alias_old_target got=%h exp=00000104", bus0.predict_target); end
        lookup(alias_pc); #1;
        checks += 2;
        if (bus0.predict_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got=%b exp=1", bus0.predict_hit); end
        if (bus0.predict_target !== 32'h200) begin errors++; $display("FAIL alias_new_target got=%h exp=00000200", bus0.predict_target); end
        advance();
    endtask

    task automatic test_gshare();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            upd(32'h200, 1, 0, 1, 32'h300);
            advance();
        end
        lookup(32'h100); #1;
        checks += 3;
        if (bus1.predict_index !== 4'hF) begin errors++; $display("FAIL gshare_index got=%h exp=f", bus1.predict_index); end
        if (bus0.predict_index !== 4'h0) begin errors++; $display("FAIL bimodal_index got=%h exp=0", bus0.predict_index); end
        if (bus1.predict_hit !== 1'b0) begin errors++; $display("FAIL gshare_hit got=%b exp=0", bus1.predict_hit); end
        advance();
        upd(32'h300, 0, 1, 1, 32'h700);
        advance();
        lookup(32'h100); #1;
        checks++;
        if (bus1.predict_index !== 4'hF) begin errors++; $display("FAIL gshare_jump_nohist got=%h exp=f", bus1.predict_index); end
        advance();
        upd(32'h204, 1, 0, 0, 32'h0);
        advance();
        lookup(32'h100); #1;
        checks++;
        if (bus1.predict_index !== 4'hE) begin errors++; $display("FAIL gshare_nt_hist got=%h exp=e", bus1.predict_index); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] pc, upc;
        bit          g_hit [2], g_tk [2];
        logic [31:0] g_tgt [2];
        logic [IDX_W-1:0] g_idx [2];
        logic [15:0] g_mis [2];
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            pc  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h1000)
                  + 32'(64 * $urandom_range(0, 2)) + 32'(4 * $urandom_range(0, 15));
            upc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h1000)
                  + 32'(64 * $urandom_range(0, 2)) + 32'(4 * $urandom_range(0, 15));
            set_in(pc, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                   1'($urandom), upc, $urandom, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0);
            #1;
            g_hit[0] = bus0.predict_hit;    g_hit[1] = bus1.predict_hit;
            g_tk[0]  = bus0.predict_taken;  g_tk[1]  = bus1.predict_taken;
            g_tgt[0] = bus0.predict_target; g_tgt[1] = bus1.predict_target;
            g_idx[0] = bus0.predict_index;  g_idx[1] = bus1.predict_index;
            g_mis[0] = bus0.mispred_cnt;    g_mis[1] = bus1.mispred_cnt;
            for (int m = 0; m < 2; m++) begin
                checks += 5;
                if (g_hit[m] !== exp_hit(m, pc)) begin errors++; $display("FAIL rnd_hit mode=%0d n=%0d got=%b exp=%b", m, n, g_hit[m], exp_hit(m, pc)); end
                if (g_tk[m] !== exp_taken(m, pc)) begin errors++; $display("FAIL rnd_taken mode=%0d n=%0d got=%b exp=%b", m, n, g_tk[m], exp_taken(m, pc)); end
                if (g_tgt[m] !== exp_target(m, pc)) begin errors++; $display("FAIL rnd_target mode=%0d n=%0d got=%h exp=%h", m, n, g_tgt[m], exp_target(m, pc)); end
                if (g_idx[m] !== IDX_W'(model_index(m, pc))) begin errors++; $display("FAIL rnd_index mode=%0d n=%0d got=%h exp=%h", m, n, g_idx[m], model_index(m, pc)); end
                if (g_mis[m] !== 16'(m_mis[m])) begin errors++; $display("FAIL rnd_mispred mode=%0d n=%0d got=%h exp=%h", m, n, g_mis[m], m_mis[m]); end
            end
            advance();
        end
    endtask

    task automatic test_mispred_sat();
        do_reset();
        for (int n = 1; n <= 65600; n++) begin
            set_in(32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 0);
            advance();
            if (n == 1000 || n == 65534) begin
                #1;
                checks++;
                if (bus0.mispred_cnt !== 16'(n)) begin errors++; $display("FAIL mispred_count n=%0d got=%h exp=%h", n, bus0.mispred_cnt, 16'(n)); end
            end
        end
        lookup(32'h0); #1;
        checks += 2;
        if (bus0.mispred_cnt !== 16'hFFFF) begin errors++; $display("FAIL mispred_sat got=%h exp=ffff", bus0.mispred_cnt); end
        if (bus1.mispred_cnt !== 16'(m_mis[1])) begin errors++; $display("FAIL mispred_sat_gshare got=%h exp=%h", bus1.mispred_cnt, m_mis[1]); end
        advance();
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        set_in(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 1, 0);
        advance();
        rst = 1'b0;
        lookup(32'h100); #1;
        checks += 3;
        if (bus0.predict_hit !== 1'b0) begin errors++; $display("FAIL rstprio_hit got=%b exp=0", bus0.predict_hit); end
        if (bus0.predict_target !== 32'h104) begin errors++; $display("FAIL rstprio_target got=%h exp=00000104", bus0.predict_target); end
        if (bus0.mispred_cnt !== 16'h0) begin errors++; $display("FAIL rstprio_mispred got=%h exp=0000", bus0.mispred_cnt); end
        advance();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        lookup(32'h0);
        @(negedge clk);
        test_reset();
        test_allocate();
        test_counter();
        test_jump();
        test_alias();
        test_gshare();
        test_random();
        test_mispred_sat();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
